osc_reset_sequencer: RTL and testbench
======================================

OSC_RESET_SEQUENCER -- requirements
Module: osc_reset_sequencer

Interface
REQ-001 SHALL have parameter SYNC_STAGES, default 2, number of synchronizer flops per asynchronous input (legal 2..4).
REQ-002 SHALL have parameter LOCK_STABLE_CYCLES, default 1024, consecutive synchronized-lock cycles required before reset release (20.48 us at 50 MHz; legal 2..65535).
REQ-003 SHALL have parameter RST_HOLD_CYCLES, default 16, cycles FABRIC_RST stays asserted in HOLD (legal 1..255).
REQ-004 SHALL have port CLK  input  1  50 MHz RC oscillator clock from the on-chip oscillator; sole clock.
REQ-005 SHALL have port RST  input  1  reset, synchronous to CLK, active-high.
REQ-006 SHALL have port PLL_LOCK  input  1  CCC lock, asynchronous to CLK.
REQ-007 SHALL have port INIT_DONE  input  1  device init/POR complete, asynchronous to CLK.
REQ-008 SHALL have port SW_RST_REQ  input  1  software reset request, synchronous to CLK, one-cycle pulse.
REQ-009 SHALL have port FABRIC_RST  output  1  active-high fabric reset, registered.
REQ-010 SHALL have port RST_DONE  output  1  high only when the fabric is out of reset, registered.
REQ-011 SHALL have port LOCK_LOSS_CNT  output  8  count of lock losses while in RUN, saturating.
REQ-012 SHALL have port STATE  output  2  current state encoding (IDLE=0, WAIT_LOCK=1, HOLD=2, RUN=3).

Function
REQ-013 SHALL pass PLL_LOCK and INIT_DONE each through SYNC_STAGES flops; lock_s and init_s denote the synchronized values; all decisions use only these.
REQ-014 SHALL implement states IDLE, WAIT_LOCK, HOLD, RUN; FABRIC_RST=1 and RST_DONE=0 in every state except RUN, where FABRIC_RST=0 and RST_DONE=1.
REQ-015 SHALL register outputs so FABRIC_RST, RST_DONE and STATE change on the same edge as the state register, with no extra latency.
REQ-016 IDLE: SHALL move to WAIT_LOCK on the first edge where init_s=1.
REQ-017 WAIT_LOCK: SHALL count consecutive cycles with lock_s=1, clearing the count to 0 on any cycle with lock_s=0, and SHALL enter HOLD on the edge completing exactly LOCK_STABLE_CYCLES consecutive high cycles.
REQ-018 HOLD: SHALL remain in HOLD exactly RST_HOLD_CYCLES cycles, then enter RUN.
REQ-019 RUN: lock_s=0 SHALL move to WAIT_LOCK with a cleared stability count and increment LOCK_LOSS_CNT by 1, saturating at 255.
REQ-020 HOLD or RUN: SW_RST_REQ=1 with lock_s=1 SHALL enter or restart HOLD with a full RST_HOLD_CYCLES count; SW_RST_REQ SHALL be ignored in IDLE and WAIT_LOCK.
REQ-021 HOLD: lock_s=0 SHALL move to WAIT_LOCK without incrementing LOCK_LOSS_CNT.
REQ-022 Priority on simultaneous events SHALL be init_s=0 (go to IDLE from any state) > lock_s=0 > SW_RST_REQ.
REQ-023 Counters SHALL be sized to their parameter maximum (the $clog2 rule) and SHALL NOT wrap.

Reset
REQ-024 RST=1 at a CLK edge SHALL force STATE=IDLE, FABRIC_RST=1, RST_DONE=0, LOCK_LOSS_CNT=0, all counters 0 and all synchronizer flops 0, regardless of state.
REQ-025 Assertion of RST in mid-sequence (any state) SHALL behave identically to REQ-024; the sequence restarts from IDLE after RST deasserts.

Structure
REQ-026 Shared package fpga_soc_rst_pkg SHALL hold the state enum typedef (2-bit) and the default parameter constants.
REQ-027 SHALL instantiate sub-module sync_bit (parameterized SYNC_STAGES-flop synchronizer) once per asynchronous input; the FSM and counters live in the top module.

Verification (bench parameters LOCK_STABLE_CYCLES=8, RST_HOLD_CYCLES=4, SYNC_STAGES=2)
REQ-028 Boot: RST released, INIT_DONE=1, PLL_LOCK=1 held -> STATE goes 0 to 1 to 2 to 3; FABRIC_RST falls exactly 8+4 cycles after entering WAIT_LOCK; RST_DONE rises on the same edge.
REQ-029 Lock glitch: PLL_LOCK drops for 3 cycles after 6 high cycles in WAIT_LOCK -> count restarts; HOLD is entered only after 8 further consecutive high lock_s cycles.
REQ-030 Lock loss in RUN: PLL_LOCK low 1 cycle -> STATE=1, FABRIC_RST=1, LOCK_LOSS_CNT 0 to 1; repeat 300 times -> LOCK_LOSS_CNT=255.
REQ-031 SW reset: SW_RST_REQ pulse in RUN -> FABRIC_RST=1 for exactly 4 cycles, then RUN; a second pulse on HOLD cycle 2 extends HOLD to 2+4 cycles total.
REQ-032 Simultaneous events: INIT_DONE falls while PLL_LOCK falls and SW_RST_REQ=1 in RUN -> STATE=IDLE and LOCK_LOSS_CNT unchanged.
REQ-033 Mid-operation reset: RST=1 for 1 cycle during HOLD -> all outputs match REQ-024 on the next edge; the sequence repeats from IDLE.

Source files
------------

// File: rtl/fpga_soc_rst_pkg.sv
// Shared definitions for the oscillator-clocked fabric reset sequencer.
// Holds the 2-bit state encoding (also driven out on the STATE port) and
// the default values for the sequencer parameters.
package fpga_soc_rst_pkg;

  // Encoding is externally visible on STATE, so values are fixed.
  typedef enum logic [1:0] {
    ST_IDLE      = 2'd0,
    ST_WAIT_LOCK = 2'd1,
    ST_HOLD      = 2'd2,
    ST_RUN       = 2'd3
  } rst_state_e;

  localparam int DEF_SYNC_STAGES        = 2;
  localparam int DEF_LOCK_STABLE_CYCLES = 1024;
  localparam int DEF_RST_HOLD_CYCLES    = 16;

  localparam logic [7:0] LOSS_CNT_MAX = 8'hFF;

endpackage

// File: rtl/sync_bit.sv
// Multi-flop synchronizer for a single asynchronous level signal.
// Ports:
//   clk_i  - destination clock
//   rst_i  - synchronous active-high reset, clears every stage
//   d_i    - asynchronous input
//   q_o    - synchronized output (last stage)
module sync_bit #(
  parameter int STAGES = 2
) (
  input  logic clk_i,
  input  logic rst_i,
  input  logic d_i,
  output logic q_o
);

  logic [STAGES-1:0] sync_q;

  // Shift chain: the input enters at bit 0 and emerges from the top bit.
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      sync_q <= '0;
    end else begin
      sync_q <= {sync_q[STAGES-2:0], d_i};
    end
  end

  assign q_o = sync_q[STAGES-1];

endmodule

// File: rtl/osc_reset_sequencer.sv
// Fabric reset sequencer running from the on-chip RC oscillator.
// Waits for device init, then for a stable PLL lock, holds fabric reset for
// a fixed number of cycles and finally releases it. Lock losses while
// running are counted (saturating) and send the sequencer back to waiting.
// Ports:
//   CLK           - oscillator clock, sole clock
//   RST           - synchronous active-high reset
//   PLL_LOCK      - PLL lock, asynchronous
//   INIT_DONE     - device init complete, asynchronous
//   SW_RST_REQ    - synchronous one-cycle software reset request
//   FABRIC_RST    - registered active-high fabric reset
//   RST_DONE      - registered, high only in RUN
//   LOCK_LOSS_CNT - saturating count of lock losses seen in RUN
//   STATE         - current state encoding
module osc_reset_sequencer
  import fpga_soc_rst_pkg::*;
#(
  parameter int SYNC_STAGES        = DEF_SYNC_STAGES,
  parameter int LOCK_STABLE_CYCLES = DEF_LOCK_STABLE_CYCLES,
  parameter int RST_HOLD_CYCLES    = DEF_RST_HOLD_CYCLES
) (
  input  logic       CLK,
  input  logic       RST,
  input  logic       PLL_LOCK,
  input  logic       INIT_DONE,
  input  logic       SW_RST_REQ,
  output logic       FABRIC_RST,
  output logic       RST_DONE,
  output logic [7:0] LOCK_LOSS_CNT,
  output logic [1:0] STATE
);

  localparam int LOCK_W = $clog2(LOCK_STABLE_CYCLES + 1);
  localparam int HOLD_W = $clog2(RST_HOLD_CYCLES + 1);
  localparam logic [LOCK_W-1:0] LOCK_LAST = LOCK_W'(LOCK_STABLE_CYCLES - 1);
  localparam logic [HOLD_W-1:0] HOLD_LAST = HOLD_W'(RST_HOLD_CYCLES - 1);

  logic lock_s;
  logic init_s;

  rst_state_e        state_q, state_d;
  logic [LOCK_W-1:0] lock_cnt_q, lock_cnt_d;
  logic [HOLD_W-1:0] hold_cnt_q, hold_cnt_d;
  logic [7:0]        loss_cnt_q, loss_cnt_d;
  logic              fabric_rst_q, fabric_rst_d;
  logic              rst_done_q, rst_done_d;

  sync_bit #(.STAGES(SYNC_STAGES)) u_sync_lock (
    .clk_i (CLK),
    .rst_i (RST),
    .d_i   (PLL_LOCK),
    .q_o   (lock_s)
  );

  sync_bit #(.STAGES(SYNC_STAGES)) u_sync_init (
    .clk_i (CLK),
    .rst_i (RST),
    .d_i   (INIT_DONE),
    .q_o   (init_s)
  );

  // Next-state logic. Losing init overrides everything, then losing lock,
  // then a software request. Counters hold the number of completed cycles
  // minus one, so the transition fires on the edge that completes the span.
  always_comb begin
    state_d    = state_q;
    lock_cnt_d = lock_cnt_q;
    hold_cnt_d = hold_cnt_q;
    loss_cnt_d = loss_cnt_q;

    if (!init_s) begin
      state_d    = ST_IDLE;
      lock_cnt_d = '0;
      hold_cnt_d = '0;
    end else begin
      case (state_q)
        ST_IDLE: begin
          state_d    = ST_WAIT_LOCK;
          lock_cnt_d = '0;
          hold_cnt_d = '0;
        end
        ST_WAIT_LOCK: begin
          if (!lock_s) begin
            lock_cnt_d = '0;
          end else if (lock_cnt_q == LOCK_LAST) begin
            state_d    = ST_HOLD;
            lock_cnt_d = '0;
            hold_cnt_d = '0;
          end else begin
            lock_cnt_d = lock_cnt_q + LOCK_W'(1);
          end
        end
        ST_HOLD: begin
          if (!lock_s) begin
            state_d    = ST_WAIT_LOCK;
            lock_cnt_d = '0;
            hold_cnt_d = '0;
          end else if (SW_RST_REQ) begin
            hold_cnt_d = '0;
          end else if (hold_cnt_q == HOLD_LAST) begin
            state_d    = ST_RUN;
            hold_cnt_d = '0;
          end else begin
            hold_cnt_d = hold_cnt_q + HOLD_W'(1);
          end
        end
        ST_RUN: begin
          if (!lock_s) begin
            state_d    = ST_WAIT_LOCK;
            lock_cnt_d = '0;
            if (loss_cnt_q != LOSS_CNT_MAX) begin
              loss_cnt_d = loss_cnt_q + 8'd1;
            end
          end else if (SW_RST_REQ) begin
            state_d    = ST_HOLD;
            hold_cnt_d = '0;
          end
        end
        default: begin
          state_d = ST_IDLE;
        end
      endcase
    end

    // Outputs are decoded from the next state so they register together
    // with the state itself.
    fabric_rst_d = (state_d != ST_RUN);
    rst_done_d   = (state_d == ST_RUN);
  end

  // State, counters and registered outputs.
  always_ff @(posedge CLK) begin
    if (RST) begin
      state_q      <= ST_IDLE;
      lock_cnt_q   <= '0;
      hold_cnt_q   <= '0;
      loss_cnt_q   <= '0;
      fabric_rst_q <= 1'b1;
      rst_done_q   <= 1'b0;
    end else begin
      state_q      <= state_d;
      lock_cnt_q   <= lock_cnt_d;
      hold_cnt_q   <= hold_cnt_d;
      loss_cnt_q   <= loss_cnt_d;
      fabric_rst_q <= fabric_rst_d;
      rst_done_q   <= rst_done_d;
    end
  end

  assign FABRIC_RST    = fabric_rst_q;
  assign RST_DONE      = rst_done_q;
  assign LOCK_LOSS_CNT = loss_cnt_q;
  assign STATE         = state_q;

endmodule

// File: tb/tb_osc_reset_sequencer.sv
// Testbench for osc_reset_sequencer with LOCK_STABLE_CYCLES=8,
// RST_HOLD_CYCLES=4, SYNC_STAGES=2. Stimulus pushes expected snapshots,
// tagged with the cycle they apply to, into a scoreboard; a monitor checks
// and retires them when that cycle is reached.
// Timing: an async input driven after posedge c is acted on by the FSM at
// posedge c+3; SW_RST_REQ driven after posedge c is acted on at c+1.
module tb_osc_reset_sequencer;

  logic       clk = 1'b0;
  logic       rst;
  logic       pllLock;
  logic       initDone;
  logic       swRstReq;
  logic       fabricRst;
  logic       rstDone;
  logic [7:0] lockLossCnt;
  logic [1:0] stateOut;

  always #10 clk = ~clk;

  osc_reset_sequencer #(
    .SYNC_STAGES        (2),
    .LOCK_STABLE_CYCLES (8),
    .RST_HOLD_CYCLES    (4)
  ) dut (
    .CLK           (clk),
    .RST           (rst),
    .PLL_LOCK      (pllLock),
    .INIT_DONE     (initDone),
    .SW_RST_REQ    (swRstReq),
    .FABRIC_RST    (fabricRst),
    .RST_DONE      (rstDone),
    .LOCK_LOSS_CNT (lockLossCnt),
    .STATE         (stateOut)
  );

  typedef struct {
    int         cyc;
    string      name;
    logic [1:0] st;
    logic       fr;
    logic       rd;
    logic [7:0] loss;
  } expect_t;

  expect_t scoreboard[$];
  int cyc = 0;
  int compared = 0;
  int mismatched = 0;
  int expLoss = 0;

  // Cycle index: value k means posedge k has just happened.
  always @(posedge clk) cyc <= cyc + 1;

  task automatic applyStimulus(input logic r, input logic i, input logic l, input logic s);
    rst      = r;
    initDone = i;
    pllLock  = l;
    swRstReq = s;
  endtask

  task automatic waitCycles(input int n);
    repeat (n) @(negedge clk);
  endtask

  // Expected fabric reset / done follow directly from the state.
  task automatic expectAt(input string name, input int delta, input logic [1:0] st, input logic [7:0] loss);
    expect_t e;
    e.cyc  = cyc + delta;
    e.name = name;
    e.st   = st;
    e.fr   = (st != 2'd3);
    e.rd   = (st == 2'd3);
    e.loss = loss;
    scoreboard.push_back(e);
  endtask

  task automatic checkOutput(input expect_t e, input bit stale);
    compared++;
    if (stale || stateOut !== e.st || fabricRst !== e.fr || rstDone !== e.rd || lockLossCnt !== e.loss) begin
      mismatched++;
      $display("[TB] FAIL %s @cyc %0d (now %0d): got st=%0d fr=%b rd=%b loss=%0d, want st=%0d fr=%b rd=%b loss=%0d",
               e.name, e.cyc, cyc, stateOut, fabricRst, rstDone, lockLossCnt, e.st, e.fr, e.rd, e.loss);
    end
  endtask

  // Monitor: retire every entry due at the current cycle.
  initial begin
    forever begin
      @(negedge clk);
      #1;
      for (int i = scoreboard.size() - 1; i >= 0; i--) begin
        if (scoreboard[i].cyc <= cyc) begin
          checkOutput(scoreboard[i], scoreboard[i].cyc < cyc);
          scoreboard.delete(i);
        end
      end
    end
  end

  initial begin
    applyStimulus(1'b1, 1'b0, 1'b0, 1'b0);
    waitCycles(2);
    expectAt("reset", 1, 2'd0, 8'd0);
    waitCycles(2);

    // Boot: WAIT_LOCK 3 cycles after release, HOLD 8 later, RUN 4 after that.
    expectAt("boot_idle", 2, 2'd0, 8'd0);
    expectAt("boot_wait", 3, 2'd1, 8'd0);
    expectAt("boot_wait_end", 10, 2'd1, 8'd0);
    expectAt("boot_hold", 11, 2'd2, 8'd0);
    expectAt("boot_hold_end", 14, 2'd2, 8'd0);
    expectAt("boot_run", 15, 2'd3, 8'd0);
    applyStimulus(1'b0, 1'b1, 1'b1, 1'b0);
    waitCycles(16);

    // Software reset in RUN: four HOLD cycles.
    expectAt("sw_hold", 1, 2'd2, 8'd0);
    expectAt("sw_hold_end", 4, 2'd2, 8'd0);
    expectAt("sw_run", 5, 2'd3, 8'd0);
    applyStimulus(1'b0, 1'b1, 1'b1, 1'b1);
    waitCycles(1);
    applyStimulus(1'b0, 1'b1, 1'b1, 1'b0);
    waitCycles(5);

    // Second pulse on HOLD cycle 2 stretches HOLD to six cycles.
    expectAt("sw2_hold", 1, 2'd2, 8'd0);
    expectAt("sw2_not_early", 5, 2'd2, 8'd0);
    expectAt("sw2_ext_end", 6, 2'd2, 8'd0);
    expectAt("sw2_run", 7, 2'd3, 8'd0);
    applyStimulus(1'b0, 1'b1, 1'b1, 1'b1);
    waitCycles(1);
    applyStimulus(1'b0, 1'b1, 1'b1, 1'b0);
    waitCycles(1);
    applyStimulus(1'b0, 1'b1, 1'b1, 1'b1);
    waitCycles(1);
    applyStimulus(1'b0, 1'b1, 1'b1, 1'b0);
    waitCycles(5);

    // 300 one-cycle lock drops in RUN; counter saturates at 255.
    for (int n = 0; n < 300; n++) begin
      if (expLoss < 255) expLoss++;
      expectAt("loss_wait", 3, 2'd1, 8'(expLoss));
      expectAt("loss_run", 15, 2'd3, 8'(expLoss));
      applyStimulus(1'b0, 1'b1, 1'b0, 1'b0);
      waitCycles(1);
      applyStimulus(1'b0, 1'b1, 1'b1, 1'b0);
      waitCycles(15);
    end

    // Init loss, lock loss and SW request hit the FSM on the same edge.
    expectAt("simul_run", 2, 2'd3, 8'd255);
    expectAt("simul_idle", 3, 2'd0, 8'd255);
    expectAt("simul_stay", 4, 2'd0, 8'd255);
    applyStimulus(1'b0, 1'b0, 1'b0, 1'b0);
    waitCycles(2);
    applyStimulus(1'b0, 1'b0, 1'b0, 1'b1);
    waitCycles(1);
    applyStimulus(1'b0, 1'b0, 1'b0, 1'b0);
    waitCycles(3);

    // Lock glitch after 6 good cycles, plus an ignored SW pulse in WAIT_LOCK.
    expectAt("glitch_wait", 3, 2'd1, 8'd255);
    expectAt("sw_ignored", 5, 2'd1, 8'd255);
    expectAt("glitch_no_hold", 11, 2'd1, 8'd255);
    expectAt("glitch_wait_end", 19, 2'd1, 8'd255);
    expectAt("glitch_hold", 20, 2'd2, 8'd255);
    expectAt("glitch_run", 24, 2'd3, 8'd255);
    applyStimulus(1'b0, 1'b1, 1'b1, 1'b0);
    waitCycles(4);
    applyStimulus(1'b0, 1'b1, 1'b1, 1'b1);
    waitCycles(1);
    applyStimulus(1'b0, 1'b1, 1'b1, 1'b0);
    waitCycles(2);
    applyStimulus(1'b0, 1'b1, 1'b0, 1'b0);
    waitCycles(3);
    applyStimulus(1'b0, 1'b1, 1'b1, 1'b0);
    waitCycles(15);

    // One-cycle RST during HOLD, then full restart from IDLE.
    expectAt("mid_hold", 1, 2'd2, 8'd255);
    expectAt("mid_reset", 2, 2'd0, 8'd0);
    expectAt("mid_idle", 4, 2'd0, 8'd0);
    expectAt("mid_wait", 5, 2'd1, 8'd0);
    expectAt("mid_hold2", 13, 2'd2, 8'd0);
    expectAt("mid_run", 17, 2'd3, 8'd0);
    applyStimulus(1'b0, 1'b1, 1'b1, 1'b1);
    waitCycles(1);
    applyStimulus(1'b1, 1'b1, 1'b1, 1'b0);
    waitCycles(1);
    applyStimulus(1'b0, 1'b1, 1'b1, 1'b0);
    waitCycles(19);

    foreach (scoreboard[i]) begin
      compared++;
      mismatched++;
      $display("[TB] FAIL %s never checked (due cyc %0d)", scoreboard[i].name, scoreboard[i].cyc);
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
    $finish;
  end

endmodule
